// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: valid/ready writeback source bundle feeding one arbiter FIFO.
//   valid/ready          : handshake; an entry transfers on an edge where both are 1
//   reg1Data/reg2Data    : result data (addressSize bits)
//   reg1Address/reg2Address : destination register numbers (regWidth bits)
//   reg1Wb/reg2Wb        : per-register writeback enables
//   is64Bit              : 64-bit result flag
//   modport master = producing unit, modport slave = arbiter
interface writeback_arbiter_if #(
   parameter int addressSize = 64,
   parameter int regWidth = 5
);
   logic valid, ready;
   logic [addressSize-1:0] reg1Data, reg2Data;
   logic [regWidth-1:0] reg1Address, reg2Address;
   logic reg1Wb, reg2Wb, is64Bit;
   modport master (
      output valid, reg1Data, reg2Data, reg1Address, reg2Address, reg1Wb, reg2Wb, is64Bit,
      input ready
   );
   modport slave (
      input valid, reg1Data, reg2Data, reg1Address, reg2Address, reg1Wb, reg2Wb, is64Bit,
      output ready
   );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin commit of fx / ldSt writeback results through per-source FIFOs.
//   clock_i, reset_i (sync, active-low)
//   fxSrc_i, ldStSrc_i : writeback_arbiter_if.slave source ports (valid/ready + payload)
//   regWritebackFunctionalUnitCode_o : unit code of the committed entry, IdleUnitCode when none
//   reg1/reg2 WritebackData_o, WritebackAddress_o, isWriteback_o, is64Bit_o : registered commit
//   fxCommitCount_o, ldStCommitCount_o : per-source commit counters, live only when the
//   macro WB_COMMIT_COUNTERS_EN is defined, otherwise tied to 0
module writeback_arbiter #(
   parameter int addressSize = 64,
   parameter int regWidth = 5,
   parameter int fifoDepth = 2,
   parameter logic [2:0] FXUnitCode = 3'd0,
   parameter logic [2:0] LdStUnitCode = 3'd2,
   parameter logic [2:0] IdleUnitCode = 3'd7
) (
   input  logic clock_i,
   input  logic reset_i,
   writeback_arbiter_if.slave fxSrc_i,
   writeback_arbiter_if.slave ldStSrc_i,
   output logic [2:0] regWritebackFunctionalUnitCode_o,
   output logic [addressSize-1:0] reg1WritebackData_o,
   output logic [addressSize-1:0] reg2WritebackData_o,
   output logic [regWidth-1:0] reg1WritebackAddress_o,
   output logic [regWidth-1:0] reg2WritebackAddress_o,
   output logic reg1isWriteback_o,
   output logic reg2isWriteback_o,
   output logic is64Bit_o,
   output logic [31:0] fxCommitCount_o,
   output logic [31:0] ldStCommitCount_o
);
   // entry layout, LSB first: reg1Data, reg2Data, reg1Address, reg2Address, reg1Wb, reg2Wb, is64Bit
   localparam int A1 = 2 * addressSize;
   localparam int A2 = A1 + regWidth;
   localparam int F = A2 + regWidth;
   localparam int EW = F + 3;
   localparam int PW = $clog2(fifoDepth);
   localparam int CW = PW + 1;
   logic [EW-1:0] ent_in [2];
   logic [EW-1:0] mem_q [2][fifoDepth];
   logic [PW-1:0] rd_q [2];
   logic [PW-1:0] wr_q [2];
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];
   logic [1:0] valid, push, pop, ne, rdy_q;
   logic last_q, gnt, any;
   logic [EW-1:0] out_q, out_d;
   logic [2:0] code_q, code_d;
   assign ent_in[0] = {fxSrc_i.is64Bit, fxSrc_i.reg2Wb, fxSrc_i.reg1Wb, fxSrc_i.reg2Address,
                       fxSrc_i.reg1Address, fxSrc_i.reg2Data, fxSrc_i.reg1Data};
   assign ent_in[1] = {ldStSrc_i.is64Bit, ldStSrc_i.reg2Wb, ldStSrc_i.reg1Wb, ldStSrc_i.reg2Address,
                       ldStSrc_i.reg1Address, ldStSrc_i.reg2Data, ldStSrc_i.reg1Data};
   assign valid = {ldStSrc_i.valid, fxSrc_i.valid};
   // ready is a flop fed from next-state occupancy, so no input reaches it combinationally
   assign fxSrc_i.ready = rdy_q[0];
   assign ldStSrc_i.ready = rdy_q[1];
   assign push = valid & rdy_q;
   assign ne = {cnt_q[1] != '0, cnt_q[0] != '0};
   assign any = |ne;
   // last_q: 0 = fx granted last, 1 = ldSt granted last
   assign gnt = ne[1] && (!ne[0] || !last_q);
   assign pop = any ? (gnt ? 2'b10 : 2'b01) : 2'b00;
   always_comb begin
      for (int s = 0; s < 2; s++) cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
      // idle cycles keep data/addresses but drop both writeback flags
      out_d = any ? mem_q[gnt][rd_q[gnt]] : {out_q[EW-1], 2'b00, out_q[F-1:0]};
      code_d = any ? (gnt ? LdStUnitCode : FXUnitCode) : IdleUnitCode;
   end
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         for (int s = 0; s < 2; s++) begin
            rd_q[s] <= '0;
            wr_q[s] <= '0;
            cnt_q[s] <= '0;
         end
         rdy_q <= 2'b00;
         last_q <= 1'b1;
         out_q <= '0;
         code_q <= IdleUnitCode;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
               mem_q[s][wr_q[s]] <= ent_in[s];
               wr_q[s] <= wr_q[s] + 1'b1;
            end
            if (pop[s]) rd_q[s] <= rd_q[s] + 1'b1;
            cnt_q[s] <= cnt_d[s];
            rdy_q[s] <= cnt_d[s] < CW'(fifoDepth);
         end
         if (any) last_q <= gnt;
         out_q <= out_d;
         code_q <= code_d;
      end
   end
   assign regWritebackFunctionalUnitCode_o = code_q;
   assign reg1WritebackData_o = out_q[0 +: addressSize];
   assign reg2WritebackData_o = out_q[addressSize +: addressSize];
   assign reg1WritebackAddress_o = out_q[A1 +: regWidth];
   assign reg2WritebackAddress_o = out_q[A2 +: regWidth];
   assign reg1isWriteback_o = out_q[F];
   assign reg2isWriteback_o = out_q[F+1];
   assign is64Bit_o = out_q[F+2];
`ifdef WB_COMMIT_COUNTERS_EN
   logic [31:0] fx_cnt_q, ls_cnt_q;
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         fx_cnt_q <= '0;
         ls_cnt_q <= '0;
      end else begin
         if (pop[0]) fx_cnt_q <= fx_cnt_q + 32'd1;
         if (pop[1]) ls_cnt_q <= ls_cnt_q + 32'd1;
      end
   end
   assign fxCommitCount_o = fx_cnt_q;
   assign ldStCommitCount_o = ls_cnt_q;
`else
   assign fxCommitCount_o = '0;
   assign ldStCommitCount_o = '0;
`endif
endmodule
